// File: rtl/piso_mc_pkg.sv
// Shared types and default sizing for the multi-channel PISO serialiser.
package piso_mc_pkg;

  localparam int unsigned DefaultWidth    = 40;
  localparam int unsigned DefaultChannels = 2;

  typedef enum logic {
    StIdle,
    StShift
  } state_e;

endpackage

// File: rtl/piso_mc_lane.sv
// One serial lane: parallel load, per-edge shift and a registered serial bit.
module piso_mc_lane
  import piso_mc_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic             serial
);

  logic [WIDTH-1:0] sreg_q;
  logic             bit_q;

  // Load presents the first bit at once; shift presents the next; otherwise the line idles low.
  always_ff @(posedge clk) begin
    if (clear) begin
      sreg_q <= '0;
      bit_q  <= 1'b0;
    end else if (load) begin
      if (MSB_FIRST != 0) begin
        bit_q  <= data[WIDTH-1];
        sreg_q <= {data[WIDTH-2:0], 1'b0};
      end else begin
        bit_q  <= data[0];
        sreg_q <= {1'b0, data[WIDTH-1:1]};
      end
    end else if (shift) begin
      if (MSB_FIRST != 0) begin
        bit_q  <= sreg_q[WIDTH-1];
        sreg_q <= {sreg_q[WIDTH-2:0], 1'b0};
      end else begin
        bit_q  <= sreg_q[0];
        sreg_q <= {1'b0, sreg_q[WIDTH-1:1]};
      end
    end else begin
      bit_q <= 1'b0;
    end
  end

  assign serial = bit_q;

endmodule

// File: rtl/piso_mc.sv
// Multi-channel parallel-in/serial-out with a double-buffered holding word.
// Optional feature: define PISO_MC_OVERRUN_EN to enable sticky Overrun detection.
module piso_mc
  import piso_mc_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter int unsigned CHANNELS  = DefaultChannels,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                      Sclk,
  input  logic                      Clear,
  input  logic                      p2s_en,
  input  logic                      Frame,
  input  logic [CHANNELS*WIDTH-1:0] Shift_done,
  output logic [CHANNELS-1:0]       SerialOut,
  output logic                      OutReady,
  output logic                      Busy,
  output logic                      Overrun
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  state_e                    state_q;
  logic [CntW-1:0]           cnt_q;
  logic                      out_ready_q;
  logic [CHANNELS*WIDTH-1:0] hold_q;
  logic                      hold_v_q;
  logic                      start;
  logic                      shift_en;

  assign start    = (state_q == StIdle) && Frame && hold_v_q;
  assign shift_en = (state_q == StShift);

  // Control FSM: cnt_q holds the number of bits still to follow the one on the line.
  always_ff @(posedge Sclk) begin
    if (Clear) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      out_ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StShift;
            cnt_q       <= CntLast;
            out_ready_q <= 1'b1;
          end else begin
            out_ready_q <= 1'b0;
          end
        end
        StShift: begin
          cnt_q       <= cnt_q - CntOne;
          out_ready_q <= 1'b1;
          // Leave SHIFT on the edge that puts the last bit out, so a restart needs no gap.
          if (cnt_q == CntOne) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q     <= StIdle;
          out_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Holding buffer: a new load wins over the clear-on-transfer of the same edge.
  always_ff @(posedge Sclk) begin
    if (Clear) begin
      hold_q   <= '0;
      hold_v_q <= 1'b0;
    end else if (p2s_en) begin
      hold_q   <= Shift_done;
      hold_v_q <= 1'b1;
    end else if (start) begin
      hold_v_q <= 1'b0;
    end
  end

`ifdef PISO_MC_OVERRUN_EN
  logic overrun_q;

  // Sticky flag: a valid holding word was replaced before it was ever transferred.
  always_ff @(posedge Sclk) begin
    if (Clear) begin
      overrun_q <= 1'b0;
    end else if (p2s_en && hold_v_q && !start) begin
      overrun_q <= 1'b1;
    end
  end

  assign Overrun = overrun_q;
`else
  assign Overrun = 1'b0;
`endif

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    piso_mc_lane #(
      .WIDTH    (WIDTH),
      .MSB_FIRST(MSB_FIRST)
    ) u_lane (
      .clk   (Sclk),
      .clear (Clear),
      .load  (start),
      .shift (shift_en),
      .data  (hold_q[k*WIDTH +: WIDTH]),
      .serial(SerialOut[k])
    );
  end

  assign OutReady = out_ready_q;
  assign Busy     = (state_q == StShift);

endmodule

// File: tb/tb_piso_mc.sv
// Scoreboard bench for piso_mc: an MSB-first and an LSB-first instance share stimulus.
module tb_piso_mc;

  localparam int unsigned W  = 40;
  localparam int unsigned CH = 2;
  localparam int unsigned DW = W * CH;

  typedef struct packed {
    logic out_ready;
    logic busy;
    logic overrun;
  } stat_t;

  logic          Sclk = 1'b0;
  logic          Clear = 1'b1;
  logic          p2s_en = 1'b0;
  logic          Frame = 1'b0;
  logic [DW-1:0] Shift_done = '0;

  logic [CH-1:0] so_m, so_l;
  logic          rdy_m, rdy_l, busy_m, busy_l, ovr_m, ovr_l;

  piso_mc #(.WIDTH(W), .CHANNELS(CH), .MSB_FIRST(1)) dut_msb (
    .Sclk(Sclk), .Clear(Clear), .p2s_en(p2s_en), .Frame(Frame), .Shift_done(Shift_done),
    .SerialOut(so_m), .OutReady(rdy_m), .Busy(busy_m), .Overrun(ovr_m)
  );

  piso_mc #(.WIDTH(W), .CHANNELS(CH), .MSB_FIRST(0)) dut_lsb (
    .Sclk(Sclk), .Clear(Clear), .p2s_en(p2s_en), .Frame(Frame), .Shift_done(Shift_done),
    .SerialOut(so_l), .OutReady(rdy_l), .Busy(busy_l), .Overrun(ovr_l)
  );

  always #5 Sclk = ~Sclk;

  int checks = 0;
  int errors = 0;

  stat_t         stat_q[$];
  logic [CH-1:0] msb_q[$];
  logic [CH-1:0] lsb_q[$];

  // Reference model state: pending word, bits still to come after the current one, sticky flag.
  logic [DW-1:0] pend = '0;
  bit            pend_v = 0;
  int            rem = 0;
  bit            ovr = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Predicts the effect of the coming clock edge and queues the expected responses.
  task automatic model_edge(input bit clr, input bit p2s, input bit frm, input logic [DW-1:0] d);
    stat_t s;
    bit    st;
    logic [CH-1:0] mv, lv;
    if (clr) begin
      pend_v = 0;
      pend   = '0;
      rem    = 0;
      ovr    = 0;
      msb_q.delete();
      lsb_q.delete();
      s = '0;
      stat_q.push_back(s);
      return;
    end
    st = (rem == 0) && frm && pend_v;
    s.out_ready = 1'b0;
    if (st) begin
      for (int i = 0; i < int'(W); i++) begin
        for (int k = 0; k < int'(CH); k++) begin
          mv[k] = pend[k*W + (W-1-i)];
          lv[k] = pend[k*W + i];
        end
        msb_q.push_back(mv);
        lsb_q.push_back(lv);
      end
      rem = W - 1;
      s.out_ready = 1'b1;
    end else if (rem > 0) begin
      rem--;
      s.out_ready = 1'b1;
    end
`ifdef PISO_MC_OVERRUN_EN
    if (p2s && pend_v && !st) ovr = 1;
`endif
    if (p2s) begin
      pend   = d;
      pend_v = 1;
    end else if (st) begin
      pend_v = 0;
    end
    s.busy    = (rem > 0);
    s.overrun = ovr;
    stat_q.push_back(s);
  endtask

  task automatic step(input bit clr, input bit p2s, input bit frm, input logic [DW-1:0] d);
    @(negedge Sclk);
    Clear      = clr;
    p2s_en     = p2s;
    Frame      = frm;
    Shift_done = d;
    model_edge(clr, p2s, frm, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0);
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  // Monitor: one expected status per edge; a serial bit is popped whenever OutReady is high.
  initial begin
    stat_t s;
    logic [CH-1:0] e;
    forever begin
      @(posedge Sclk);
      #1;
      if (stat_q.size() > 0) begin
        s = stat_q.pop_front();
        check("outready_msb", 64'(rdy_m), 64'(s.out_ready));
        check("outready_lsb", 64'(rdy_l), 64'(s.out_ready));
        check("busy_msb", 64'(busy_m), 64'(s.busy));
        check("busy_lsb", 64'(busy_l), 64'(s.busy));
        check("overrun_msb", 64'(ovr_m), 64'(s.overrun));
        check("overrun_lsb", 64'(ovr_l), 64'(s.overrun));
        if (s.out_ready) begin
          if (msb_q.size() > 0) begin
            e = msb_q.pop_front();
            check("serial_msb", 64'(so_m), 64'(e));
          end
          if (lsb_q.size() > 0) begin
            e = lsb_q.pop_front();
            check("serial_lsb", 64'(so_l), 64'(e));
          end
        end else begin
          check("serial_idle_msb", 64'(so_m), 64'(0));
          check("serial_idle_lsb", 64'(so_l), 64'(0));
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] a, b;
    a = {40'h55_AAAA_5555, 40'h80_0000_0001};
    b = {40'h12_3456_789A, 40'hF0_0F0F_F0F0};

    // Reset
    step(1, 0, 0, '0);
    step(1, 1, 1, a);
    step(1, 0, 0, '0);

    // Basic word, both bit orders
    step(0, 1, 0, a);
    step(0, 0, 1, '0);
    idle(45);

    // Single set bit on lane 0
    step(0, 1, 0, {40'h0, 40'h1});
    step(0, 0, 1, '0);
    idle(42);

    // Double buffering: B loaded mid-word, Frame held high through both words
    step(0, 1, 0, a);
    step(0, 0, 1, '0);
    for (int i = 0; i < 9; i++) step(0, 0, 1, '0);
    step(0, 1, 1, b);
    for (int i = 0; i < 80; i++) step(0, 0, 1, '0);
    idle(5);

    // Overrun: two loads without a Frame; second word is the one sent
    step(0, 1, 0, a);
    step(0, 1, 0, b);
    idle(3);
    step(0, 0, 1, '0);
    idle(45);
    step(1, 0, 0, '0);

    // Load and start on the same edge: no overrun, new word waits
    step(0, 1, 0, a);
    step(0, 1, 1, b);
    idle(42);
    step(0, 0, 1, '0);
    idle(42);

    // Clear at bit 20, then Frame without a load
    step(0, 1, 0, b);
    step(0, 0, 1, '0);
    idle(19);
    step(1, 0, 0, '0);
    idle(3);
    step(0, 0, 1, '0);
    idle(5);

    // Frame with nothing held
    step(0, 0, 1, '0);
    step(0, 0, 1, '0);
    idle(3);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 3) == 0), rand_word());
    end
    idle(50);

    @(posedge Sclk);
    #2;
    check("msb_bits_drained", 64'(msb_q.size()), 64'(0));
    check("lsb_bits_drained", 64'(lsb_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_mc.md
PISO_MC -- requirements
Module: piso_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 40, bits per channel word (2..64).
REQ-002 SHALL have parameter CHANNELS, default 2, number of parallel serial lanes (1..8).
REQ-003 SHALL have parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 first, 0 = bit 0 first.
REQ-004 SHALL have port Sclk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port Clear  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port p2s_en  input  1  load strobe for Shift_done into holding buffer.
REQ-007 SHALL have port Frame  input  1  frame sync; starts transmission of buffered word.
REQ-008 SHALL have port Shift_done  input  CHANNELS*WIDTH  parallel words; lane k = bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port SerialOut  output  CHANNELS  serial bit per lane.
REQ-010 SHALL have port OutReady  output  1  high while SerialOut carries valid bits.
REQ-011 SHALL have port Busy  output  1  high in SHIFT state.
REQ-012 SHALL have port Overrun  output  1  sticky: holding word overwritten before transmission.

Function
REQ-013 SHALL keep a holding buffer (CHANNELS*WIDTH) plus valid flag hold_v, and a shift register per lane.
REQ-014 SHALL, on p2s_en=1, capture Shift_done into holding buffer and set hold_v=1.
REQ-015 SHALL implement states IDLE and SHIFT; IDLE->SHIFT when Frame=1 and hold_v=1; SHIFT->IDLE on the edge emitting the last bit.
REQ-016 SHALL, on IDLE->SHIFT edge, transfer holding to shift registers, clear hold_v, drive first bit on SerialOut, set OutReady=1, bit counter=WIDTH-1.
REQ-017 SHALL emit exactly WIDTH bits per lane on WIDTH consecutive edges, order per MSB_FIRST, all lanes in lockstep.
REQ-018 SHALL, in IDLE without a start, drive SerialOut=0 and OutReady=0.
REQ-019 SHALL ignore Frame while in SHIFT and Frame in IDLE when hold_v=0.
REQ-020 SHALL accept p2s_en during SHIFT (double buffering) without disturbing the word in flight.
REQ-021 SHALL, on p2s_en and start on the same edge, transfer old holding to shift, then load new data with hold_v=1; no Overrun.
REQ-022 SHALL set Overrun when p2s_en=1, hold_v=1 and no transfer on that edge; new data overwrites.
REQ-023 SHALL allow back-to-back words: Frame in the first IDLE cycle after SHIFT restarts, no extra gap.
REQ-024 SHALL size the bit counter $clog2(WIDTH) bits; no wrap beyond 0.

Reset
REQ-025 SHALL, on Clear=1 at a clock edge, override all other inputs: state IDLE, hold_v=0, buffers 0, SerialOut=0, OutReady=0, Busy=0, Overrun=0.
REQ-026 SHALL abort an in-flight word on Clear mid-SHIFT; no remaining bits emitted.

Configuration
REQ-027 SHALL honour macro PISO_MC_OVERRUN_EN: defined -> Overrun logic per REQ-022, cleared only by Clear; undefined -> Overrun tied 0, no detection logic.

Structure
REQ-028 SHALL place state typedef (IDLE, SHIFT) and default WIDTH/CHANNELS constants in package piso_mc_pkg.
REQ-029 SHALL instantiate one sub-module piso_mc_lane per channel (load, shift, serial bit); control FSM/counter shared in piso_mc.

Verification
REQ-030 SHALL test: WIDTH=40, CHANNELS=2, lane0=40'h80_0000_0001, lane1=40'h55_AAAA_5555, p2s_en then Frame -> 40 bits per lane MSB first, OutReady high 40 cycles exactly.
REQ-031 SHALL test: MSB_FIRST=0, lane0=40'h1 -> first SerialOut[0]=1, next 39 bits 0.
REQ-032 SHALL test: p2s_en at bit 10 of word A with B, Frame right after A -> B follows A, no idle gap, Overrun=0.
REQ-033 SHALL test: two p2s_en without Frame between -> Overrun=1 (macro defined) / 0 (undefined); second word transmitted.
REQ-034 SHALL test: Clear at bit 20 -> next cycle SerialOut=0, OutReady=0, Busy=0; later Frame without p2s_en produces no output.
REQ-035 SHALL test: Frame with hold_v=0, and Frame held high through SHIFT -> no start, no restart mid-word.
